// File: rtl/serin.sv
// serin: multi-port asynchronous 8N1 serial receiver with per-port byte FIFOs.
//
// Each rxd line is double-flop synchronised and deserialised by its own
// small FSM that times bits from the shared one-microsecond u1clk pulse.
// Received bytes are queued in a per-port FIFO which the host drains over
// the daisy-chained peripheral bus.
//
// Register map (index = addr[LOGNPORT:0], decoded when addr[11:8]==our_addr
// and the bits between are zero):
//   0..NPORT-1 : port receive data, a claimed read pops the FIFO head
//   NPORT      : config, bits[3:0] = bauddiv, read/write
//   NPORT+1    : status, bit i = port i FIFO non-empty, read-only
//   NPORT+2    : framing-error flags, read clears (only with SERIN_FERR_EN)
//
// Bit period is 26*(bauddiv+1) u1clk pulses; the start bit is re-checked
// half a period after the falling edge is seen.
//
// Optional build macro: SERIN_FERR_EN adds the framing-error flag register.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rdwr, strobe          bus direction (1=read) and command valid
//   our_addr, addr        assigned high nibble, target address
//   busy_in/busy_out      busy chain, passed straight through
//   addr_match_in/_out    claim chain, OR-ed with this block's claim
//   datin/datout          bus data; datout = datin when not addressed
//   u1clk                 one-clk pulse per microsecond
//   rxd                   serial inputs, idle high
//
// FSM state of every port is visible as state_q[i].
module serin #(
  parameter int NPORT    = 8,
  parameter int LOGNPORT = 3,
  parameter int LB2RXSZ  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rdwr,
  input  logic             strobe,
  input  logic [3:0]       our_addr,
  input  logic [11:0]      addr,
  input  logic             busy_in,
  output logic             busy_out,
  input  logic             addr_match_in,
  output logic             addr_match_out,
  input  logic [7:0]       datin,
  output logic [7:0]       datout,
  input  logic             u1clk,
  input  logic [NPORT-1:0] rxd
);

  localparam int RW    = LOGNPORT + 1;
  localparam int DEPTH = 1 << LB2RXSZ;
  localparam int PW    = LB2RXSZ + 1;
  localparam logic [RW-1:0] REG_CFG  = RW'(NPORT);
  localparam logic [RW-1:0] REG_STAT = RW'(NPORT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_e;

  rx_state_e        state_q [NPORT];
  rx_state_e        state_d [NPORT];
  logic [8:0]       cnt_q   [NPORT];
  logic [8:0]       cnt_d   [NPORT];
  logic [2:0]       bit_q   [NPORT];
  logic [2:0]       bit_d   [NPORT];
  logic [7:0]       shreg_q [NPORT];
  logic [7:0]       shreg_d [NPORT];
  logic [PW-1:0]    wptr_q  [NPORT];
  logic [PW-1:0]    wptr_d  [NPORT];
  logic [PW-1:0]    rptr_q  [NPORT];
  logic [PW-1:0]    rptr_d  [NPORT];
  logic [7:0]       mem_q   [NPORT][DEPTH];
  logic [7:0]       mem_d   [NPORT][DEPTH];
  logic [NPORT-1:0] sync1_q, sync2_q;
  logic [3:0]       bauddiv_q, bauddiv_d;
  logic [NPORT-1:0] empty, full, push, pop;

  logic                myaddr, is_data, bus_rd, cfg_wr, claim;
  logic [RW-1:0]       reg_idx;
  logic [LOGNPORT-1:0] port_sel;
  logic [7:0]          rdata;
  logic [8:0]          bd_p1, period_m1, half_m1;

`ifdef SERIN_FERR_EN
  localparam logic [RW-1:0] REG_FERR = RW'(NPORT + 2);
  logic [NPORT-1:0] ferr_q, ferr_d, ferr_set;
  logic             ferr_rd;
`endif

  // ---------------- bus decode and readout ----------------
  assign busy_out = busy_in;
  assign myaddr   = (addr[11:8] == our_addr) && (addr[7:RW] == '0);
  assign reg_idx  = addr[RW-1:0];
  assign port_sel = addr[LOGNPORT-1:0];
  assign is_data  = ~addr[LOGNPORT];
  assign bus_rd   = strobe & myaddr & rdwr;
  assign cfg_wr   = strobe & myaddr & ~rdwr & (reg_idx == REG_CFG);

  always_comb begin
    claim = 1'b0;
    rdata = 8'h00;
    if (is_data) begin
      // Reads of an empty port and all data-register writes stay unclaimed.
      claim = rdwr & ~empty[port_sel];
      if (!empty[port_sel]) rdata = mem_q[port_sel][rptr_q[port_sel][LB2RXSZ-1:0]];
    end else if (reg_idx == REG_CFG) begin
      claim = 1'b1;
      rdata = {4'd0, bauddiv_q};
    end else if (reg_idx == REG_STAT) begin
      claim = 1'b1;
      rdata[NPORT-1:0] = ~empty;
    end
`ifdef SERIN_FERR_EN
    else if (reg_idx == REG_FERR) begin
      claim = 1'b1;
      rdata[NPORT-1:0] = ferr_q;
    end
`endif
  end

  assign addr_match_out = addr_match_in | (myaddr & claim);
  assign datout         = myaddr ? rdata : datin;

  // ---------------- FIFO flags ----------------
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      empty[i] = (wptr_q[i] == rptr_q[i]);
      full[i]  = (wptr_q[i][PW-1] != rptr_q[i][PW-1]) &&
                 (wptr_q[i][PW-2:0] == rptr_q[i][PW-2:0]);
    end
  end

  // ---------------- receive FSMs and FIFO update ----------------
  // bauddiv is sampled at every counter reload, so a config write mid-byte
  // only changes the timing from the next reload onwards.
  assign bd_p1     = {5'd0, bauddiv_q} + 9'd1;
  assign period_m1 = 9'd26 * bd_p1 - 9'd1;
  assign half_m1   = 9'd13 * bd_p1 - 9'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_d     = mem_q;
    push      = '0;
    pop       = '0;
    bauddiv_d = cfg_wr ? datin[3:0] : bauddiv_q;
`ifdef SERIN_FERR_EN
    ferr_set  = '0;
`endif
    for (int i = 0; i < NPORT; i++) begin
      // Bit timer only runs while a frame is in progress; a tick is a u1clk
      // pulse seen with the counter at zero, and every tick reloads it.
      if (u1clk && (state_q[i] == S_START || state_q[i] == S_DATA || state_q[i] == S_STOP)) begin
        if (cnt_q[i] == 9'd0) cnt_d[i] = period_m1;
        else                  cnt_d[i] = cnt_q[i] - 9'd1;
      end

      case (state_q[i])
        S_IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_START;
            cnt_d[i]   = half_m1;
          end
        end
        S_START: begin
          if (u1clk && cnt_q[i] == 9'd0) begin
            if (sync2_q[i]) begin
              state_d[i] = S_IDLE;   // too short to be a start bit
            end else begin
              state_d[i] = S_DATA;
              bit_d[i]   = 3'd0;
            end
          end
        end
        S_DATA: begin
          if (u1clk && cnt_q[i] == 9'd0) begin
            shreg_d[i] = {sync2_q[i], shreg_q[i][7:1]};
            bit_d[i]   = bit_q[i] + 3'd1;
            if (bit_q[i] == 3'd7) state_d[i] = S_STOP;
          end
        end
        S_STOP: begin
          if (u1clk && cnt_q[i] == 9'd0) begin
            if (sync2_q[i]) begin
              push[i]    = 1'b1;
              state_d[i] = S_IDLE;
            end else begin
              state_d[i] = S_BREAK;
`ifdef SERIN_FERR_EN
              ferr_set[i] = 1'b1;
`endif
            end
          end
        end
        S_BREAK: begin
          if (sync2_q[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase

      pop[i] = bus_rd & is_data & (port_sel == LOGNPORT'(i)) & ~empty[i];

      // A pop in the same cycle frees the slot, so a full FIFO still
      // accepts the byte; the pop reads the old head before the write lands.
      if (push[i] && (!full[i] || pop[i])) begin
        mem_d[i][wptr_q[i][LB2RXSZ-1:0]] = shreg_q[i];
        wptr_d[i] = wptr_q[i] + PW'(1);
      end
`ifdef SERIN_FERR_EN
      else if (push[i]) begin
        ferr_set[i] = 1'b1;
      end
`endif
      if (pop[i]) rptr_d[i] = rptr_q[i] + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      bauddiv_q <= 4'd0;
      for (int i = 0; i < NPORT; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= 9'd0;
        bit_q[i]   <= 3'd0;
        shreg_q[i] <= 8'h00;
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= 8'h00;
      end
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      bauddiv_q <= bauddiv_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      mem_q     <= mem_d;
    end
  end

`ifdef SERIN_FERR_EN
  // Read clears every flag, but a set event in the same cycle survives.
  assign ferr_rd = bus_rd & (reg_idx == REG_FERR);
  assign ferr_d  = (ferr_rd ? '0 : ferr_q) | ferr_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ferr_q <= '0;
    else          ferr_q <= ferr_d;
  end
`endif

endmodule

// File: tb/tb_serin.sv
// Bench for serin: drives 8N1 frames on rxd and bus reads/writes; every
// read pushes its expected {busy_out, addr_match_out, datout} into exp_q and
// a negedge monitor pops and compares whenever a read strobe is presented.
module tb_serin;
  localparam int         U1_DIV = 4;
  localparam logic [3:0] OUR    = 4'hA;
  localparam logic [3:0] R_CFG  = 4'd8;
  localparam logic [3:0] R_STAT = 4'd9;
  localparam logic [3:0] R_FERR = 4'd10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rdwr = 1'b0;
  logic        strobe = 1'b0;
  logic [3:0]  our_addr = OUR;
  logic [11:0] addr = 12'h000;
  logic        busy_in = 1'b0;
  logic        busy_out;
  logic        addr_match_in = 1'b0;
  logic        addr_match_out;
  logic [7:0]  datin = 8'h00;
  logic [7:0]  datout;
  logic        u1clk = 1'b0;
  logic [7:0]  rxd = 8'hFF;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q[$];
  string       name_q[$];
  logic [9:0]  mon_exp;
  string       mon_name;

  serin dut (
    .clk(clk), .reset_n(reset_n), .rdwr(rdwr), .strobe(strobe),
    .our_addr(our_addr), .addr(addr), .busy_in(busy_in), .busy_out(busy_out),
    .addr_match_in(addr_match_in), .addr_match_out(addr_match_out),
    .datin(datin), .datout(datout), .u1clk(u1clk), .rxd(rxd)
  );

  // ---------------- clock / reset / timebase ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (U1_DIV - 1) @(posedge clk);
      #1 u1clk = 1'b1;
      @(posedge clk);
      #1 u1clk = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (strobe && rdwr) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got data=%02h match=%0b, no expected entry", datout, addr_match_out);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        checks++;
        if ({busy_out, addr_match_out, datout} !== mon_exp)
          begin
            errors++;
            $display("FAIL %s: got busy=%0b match=%0b data=%02h, expected busy=%0b match=%0b data=%02h",
                     mon_name, busy_out, addr_match_out, datout, mon_exp[9], mon_exp[8], mon_exp[7:0]);
          end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a read for the current cycle and records what it must return.
  task automatic setup_rd(input logic [11:0] a, input logic [7:0] din, input logic ami,
                          input logic [7:0] exp_d, input logic exp_m, input string nm);
    addr          = a;
    datin         = din;
    addr_match_in = ami;
    busy_in       = ~busy_in;
    rdwr          = 1'b1;
    strobe        = 1'b1;
    exp_q.push_back({busy_in, exp_m, exp_d});
    name_q.push_back(nm);
  endtask

  task automatic bus_rd_raw(input logic [11:0] a, input logic [7:0] din, input logic ami,
                            input logic [7:0] exp_d, input logic exp_m, input string nm);
    @(posedge clk);
    #1 setup_rd(a, din, ami, exp_d, exp_m, nm);
    @(posedge clk);
    #1 strobe = 1'b0;
    rdwr          = 1'b0;
    addr_match_in = 1'b0;
  endtask

  task automatic rd(input logic [3:0] r, input logic [7:0] exp_d, input logic exp_m, input string nm);
    bus_rd_raw({OUR, 4'h0, r}, 8'hC7, 1'b0, exp_d, exp_m, nm);
  endtask

  task automatic wr(input logic [3:0] r, input logic [7:0] d);
    @(posedge clk);
    #1 addr = {OUR, 4'h0, r};
    datin  = d;
    rdwr   = 1'b0;
    strobe = 1'b1;
    @(posedge clk);
    #1 strobe = 1'b0;
  endtask

  // Return at an edge on which u1clk is sampled high.
  task automatic align_u1();
    do @(posedge clk); while (u1clk !== 1'b1);
  endtask

  // One 8N1 frame; ends on a clock edge with the line at the stop value.
  task automatic send_byte(input int p, input logic [7:0] b, input logic stop, input int bd);
    int bitc;
    bitc = 26 * (bd + 1) * U1_DIV;
    #1 rxd[p] = 1'b0;
    repeat (bitc) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1 rxd[p] = b[k];
      repeat (bitc) @(posedge clk);
    end
    #1 rxd[p] = stop;
    repeat (bitc) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state and pass-through
    rd(R_STAT, 8'h00, 1'b1, "reset_status");
    rd(R_CFG,  8'h00, 1'b1, "reset_config");
    rd(4'd2,   8'h00, 1'b0, "reset_empty_port");
    bus_rd_raw({~OUR, 8'h02}, 8'h96, 1'b1, 8'h96, 1'b1, "foreign_passthru");
    bus_rd_raw({OUR, 8'h12},  8'h3B, 1'b0, 8'h3B, 1'b0, "mid_bits_not_ours");

    // 1: single byte on port 2
    wr(R_CFG, 8'h00);
    send_byte(2, 8'h55, 1'b1, 0);
    rd(R_STAT, 8'h04, 1'b1, "t1_status_set");
    rd(4'd2,   8'h55, 1'b1, "t1_data");
    rd(R_STAT, 8'h00, 1'b1, "t1_status_clear");
    wr(4'd2, 8'hEE);
    rd(R_STAT, 8'h00, 1'b1, "t1_data_write_ignored");

    // 2: 5us glitch is rejected
    @(posedge clk);
    #1 rxd[0] = 1'b0;
    repeat (5 * U1_DIV) @(posedge clk);
    #1 rxd[0] = 1'b1;
    repeat (40 * U1_DIV) @(posedge clk);
    rd(R_STAT, 8'h00, 1'b1, "t2_status");
    rd(4'd0,   8'h00, 1'b0, "t2_read_unclaimed");

    // 3: overflow on port 0 while port 7 receives concurrently
    fork
      begin
        for (int v = 1; v <= 5; v++) send_byte(0, 8'(v), 1'b1, 0);
      end
      begin
        send_byte(7, 8'h11, 1'b1, 0);
        send_byte(7, 8'h22, 1'b1, 0);
        send_byte(7, 8'h33, 1'b1, 0);
      end
    join
    rd(R_STAT, 8'h81, 1'b1, "t3_status");
`ifdef SERIN_FERR_EN
    rd(R_FERR, 8'h01, 1'b1, "t3_ferr_set");
    rd(R_FERR, 8'h00, 1'b1, "t3_ferr_cleared");
`else
    bus_rd_raw({OUR, 4'h0, R_FERR}, 8'h00, 1'b0, 8'h00, 1'b0, "t3_ferr_unclaimed");
`endif
    rd(4'd0, 8'h01, 1'b1, "t3_byte1");
    rd(4'd0, 8'h02, 1'b1, "t3_byte2");
    rd(4'd0, 8'h03, 1'b1, "t3_byte3");
    rd(4'd0, 8'h04, 1'b1, "t3_byte4");
    rd(4'd0, 8'h00, 1'b0, "t3_fifth_unclaimed");
    rd(R_STAT, 8'h80, 1'b1, "t3_status_after");

    // 4: framing error then a good byte
    send_byte(0, 8'hA5, 1'b0, 0);
    repeat (100 * U1_DIV) @(posedge clk);
    #1 rxd[0] = 1'b1;
    repeat (26 * U1_DIV) @(posedge clk);
    send_byte(0, 8'h3C, 1'b1, 0);
    rd(R_STAT, 8'h81, 1'b1, "t4_status");
`ifdef SERIN_FERR_EN
    rd(R_FERR, 8'h01, 1'b1, "t4_ferr_break");
`endif
    rd(4'd0, 8'h3C, 1'b1, "t4_good_byte");
    rd(4'd0, 8'h00, 1'b0, "t4_no_more");

    // 5: bauddiv=1, port 7 full, pop lands on the push edge
    wr(R_CFG, 8'h01);
    rd(R_CFG, 8'h01, 1'b1, "t5_cfg1");
    send_byte(7, 8'h18, 1'b1, 1);
    rd(R_STAT, 8'h80, 1'b1, "t5_status_full");
    align_u1();
    fork
      send_byte(7, 8'hC3, 1'b1, 1);
      begin
        // Stop-bit sample is 247*(bauddiv+1) u1 periods after the start edge.
        repeat (247 * 2 * U1_DIV - 2) @(posedge clk);
        rd(4'd7, 8'h11, 1'b1, "t5_pop_on_push");
      end
    join
    rd(4'd7, 8'h22, 1'b1, "t5_byte2");
    rd(4'd7, 8'h33, 1'b1, "t5_byte3");
    rd(4'd7, 8'h18, 1'b1, "t5_byte4");
    rd(4'd7, 8'hC3, 1'b1, "t5_new_byte");
    rd(4'd7, 8'h00, 1'b0, "t5_empty");
    rd(R_STAT, 8'h00, 1'b1, "t5_status_empty");
    wr(R_CFG, 8'h03);
    rd(R_CFG, 8'h03, 1'b1, "t5_cfg3");
    wr(R_CFG, 8'h00);

    // 6: async reset mid-byte with data queued
    send_byte(3, 8'h12, 1'b1, 0);
    send_byte(3, 8'h34, 1'b1, 0);
    rd(R_STAT, 8'h08, 1'b1, "t6_status_queued");
    fork
      send_byte(3, 8'h99, 1'b1, 0);
      begin
        repeat (5 * 26 * U1_DIV) @(posedge clk);
        #1 reset_n = 1'b0;
        setup_rd({OUR, 4'h0, R_STAT}, 8'hC7, 1'b0, 8'h00, 1'b1, "t6_status_in_reset");
        @(posedge clk);
        #1 strobe = 1'b0;
        rdwr = 1'b0;
        rd(4'd3, 8'h00, 1'b0, "t6_port3_in_reset");
      end
    join
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    send_byte(3, 8'h7E, 1'b1, 0);
    rd(R_STAT, 8'h08, 1'b1, "t6_status_after");
    rd(4'd3,   8'h7E, 1'b1, "t6_byte");
    rd(4'd3,   8'h00, 1'b0, "t6_empty");
    rd(R_STAT, 8'h00, 1'b1, "t6_status_final");

    // ---------------- final report ----------------
    repeat (4) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
